vx_afu_dcr_queue: RTL and testbench
===================================

// Module: vx_afu_dcr_queue
// PURPOSE
//  Decoupling queue between the AFU AXI-lite control slave and the GPU DCR bus. The control slave
//  issues single-cycle DCR write pulses with no backpressure. This block buffers those pulses and
//  replays them to the core DCR port with a valid/ready handshake. It also holds off kernel start
//  until every queued DCR write has been accepted, and discards pending writes on AFU soft reset.
// PARAMETERS
//  DEPTH       8                   queue entries; power of 2, >= 2
//  ADDR_WIDTH  VX_DCR_ADDR_WIDTH   DCR address width
//  DATA_WIDTH  VX_DCR_DATA_WIDTH   DCR data width
// PORTS
//  clk            in   1                 clock
//  reset_n        in   1                 asynchronous reset, active-low
//  in_valid       in   1                 DCR write pulse from control slave; no backpressure
//  in_addr        in   ADDR_WIDTH        DCR address
//  in_data        in   DATA_WIDTH        DCR value
//  flush          in   1                 soft-reset pulse (ap_reset); discards queued writes
//  out_valid      out  1                 DCR write request to GPU
//  out_addr       out  ADDR_WIDTH        head entry address
//  out_data       out  DATA_WIDTH        head entry data
//  out_ready      in   1                 GPU accepts head entry
//  ap_start_in    in   1                 start level from control slave
//  ap_start_out   out  1                 gated start to GPU
//  overflow       out  1                 sticky: a write was dropped because the queue was full
//  overflow_clr   in   1                 clears overflow
//  count          out  $clog2(DEPTH)+1   current occupancy
// BEHAVIOUR
//  - Reset (reset_n=0, async): pointers=0, state=RUN, overflow=0, out_valid=0, ap_start_out=0, count=0.
//  - Storage: circular buffer. rd/wr pointers are $clog2(DEPTH)+1 bits wide, with the MSB as the wrap bit.
//    empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
//  - out_valid = ~empty. out_addr/out_data = mem[rd_ptr] (first-word fall-through). pop = out_valid & out_ready.
//  - push = in_valid & (~full | pop). A write that arrives while the queue is full and a pop occurs
//    in the same cycle is accepted (0-cycle slot reuse).
//  - in_valid & full & ~pop: the entry is dropped and overflow is set next cycle.
//    If overflow_clr is asserted in the same cycle as a drop, set wins.
//  - Latency: push at cycle N gives out_valid=1 at N+1 when the queue was empty.
//  - count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1); range 0..DEPTH.
//  - ap_start_out = ap_start_in & empty & ~in_valid & (state==RUN).
//    Combinational; it deasserts the same cycle a new write arrives.
//  - FSM states RUN, FLUSH:
//     RUN  : normal operation. On flush:
//            if out_valid & ~out_ready: go to FLUSH, set wr_ptr=rd_ptr+1 (head kept, to preserve valid stability);
//            else: wr_ptr=rd_ptr (empty), stay in RUN.
//     FLUSH: in_valid is dropped silently (no overflow). Exit to RUN on pop.
//            A further flush pulse while in FLUSH has no effect.
//  - A flush coincident with in_valid: the flush takes priority and the new write is discarded.
//  - When DEPTH entries are queued, wrap-around of both pointers must preserve FIFO order.
// CONFIGURATION
//  VX_AFU_DCR_QUEUE_STATS_EN defined:
//   adds outputs stat_pushed[31:0] and stat_dropped[31:0]. Both are saturating counters of accepted
//   and dropped writes; dropped includes those discarded in FLUSH. Both clear on flush and on reset.
//  Not defined: the ports are absent and no counter logic is generated.
// STRUCTURE
//  - VX_gpu_pkg supplies VX_DCR_ADDR_WIDTH and VX_DCR_DATA_WIDTH.
//  - Add dcr_req_t (packed struct {addr; data}) and typedef enum logic {DQ_RUN, DQ_FLUSH} dcr_q_state_e
//    to VX_gpu_pkg.
//  - One sub-module, vx_afu_dcr_queue_mem: DEPTH x dcr_req_t register array with one write port
//    and one async read port. No reset on the data array.
// TESTING
//  1 Reset then push A=(0x001,0x11), out_ready=1 -> out_valid at +1 cycle, A accepted,
//    count returns to 0, overflow=0.
//  2 DEPTH=8, out_ready=0, 9 pushes -> count=8, 9th dropped, overflow=1;
//    overflow_clr -> overflow=0; drain yields entries 1..8 in order.
//  3 Full queue, push and pop in the same cycle -> count stays 8 and the new entry appears last in order.
//  4 ap_start_in=1 with 3 queued entries -> ap_start_out=0 until the 3rd pop, then 1 the next cycle.
//    A new push while started -> ap_start_out drops the same cycle.
//  5 4 queued, out_valid=1, out_ready=0, flush -> state FLUSH, head held stable, pushes ignored.
//    out_ready=1 -> head accepted, then count=0 and state RUN.
//  6 STATS_EN build: 10 pushes into DEPTH=8 with out_ready=0 -> stat_pushed=8, stat_dropped=2;
//    flush -> both 0.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions: DCR bus widths, the DCR request record and the DCR queue state type.
package VX_gpu_pkg;

    localparam int unsigned VX_DCR_ADDR_WIDTH = 12;
    localparam int unsigned VX_DCR_DATA_WIDTH = 32;

    typedef struct packed {
        logic [VX_DCR_ADDR_WIDTH-1:0] addr;
        logic [VX_DCR_DATA_WIDTH-1:0] data;
    } dcr_req_t;

    typedef enum logic {
        DQ_RUN,
        DQ_FLUSH
    } dcr_q_state_e;

endpackage

// File: rtl/vx_afu_dcr_queue_if.sv
// DCR write channels around the queue: pulse input from the control slave, valid/ready output to the GPU.
interface vx_afu_dcr_queue_if
    import VX_gpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = VX_DCR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = VX_DCR_DATA_WIDTH
) ();

    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output out_valid, out_addr, out_data
    );

endinterface

// File: rtl/vx_afu_dcr_queue_mem.sv
// DEPTH-entry DCR request storage: one synchronous write port, one asynchronous read port, no reset.
module vx_afu_dcr_queue_mem
    import VX_gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  dcr_req_t                 wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output dcr_req_t                 rdata
);

    dcr_req_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vx_afu_dcr_queue.sv
// Buffers DCR write pulses and replays them with valid/ready; gates kernel start until drained.
// Optional statistics counters are enabled by defining VX_AFU_DCR_QUEUE_STATS_EN.
module vx_afu_dcr_queue
    import VX_gpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = VX_DCR_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = VX_DCR_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_afu_dcr_queue_if.slave      dcr,
    input  logic                   flush,
    input  logic                   ap_start_in,
    output logic                   ap_start_out,
    output logic                   overflow,
    input  logic                   overflow_clr,
    output logic [$clog2(DEPTH):0] count
`ifdef VX_AFU_DCR_QUEUE_STATS_EN
    ,
    output logic [31:0]            stat_pushed,
    output logic [31:0]            stat_dropped
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    dcr_q_state_e    state_q, state_d;
    logic            overflow_q, overflow_d;
    logic            empty, full, pop, push, drop;
    dcr_req_t        wr_req, rd_req;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    assign pop   = ~empty & dcr.out_ready;

    assign wr_req.addr = dcr.in_addr;
    assign wr_req.data = dcr.in_data;
    assign head_addr   = rd_req.addr;
    assign head_data   = rd_req.data;

    assign dcr.out_valid = ~empty;
    assign dcr.out_addr  = head_addr;
    assign dcr.out_data  = head_data;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        push     = 1'b0;
        drop     = 1'b0;
        unique case (state_q)
            DQ_RUN: begin
                if (flush) begin
                    // A stalled head must stay valid until taken, so keep exactly that entry.
                    if (~empty & ~dcr.out_ready) begin
                        state_d  = DQ_FLUSH;
                        wr_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                    end else begin
                        wr_ptr_d = rd_ptr_d;
                    end
                end else begin
                    push     = dcr.in_valid & (~full | pop);
                    drop     = dcr.in_valid & full & ~pop;
                    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
                end
            end
            DQ_FLUSH: begin
                if (pop) begin
                    state_d = DQ_RUN;
                end
            end
            default: state_d = DQ_RUN;
        endcase
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= DQ_RUN;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    vx_afu_dcr_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_req),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_req)
    );

    assign count        = wr_ptr_q - rd_ptr_q;
    assign overflow     = overflow_q;
    assign ap_start_out = ap_start_in & empty & ~dcr.in_valid & (state_q == DQ_RUN);

`ifdef VX_AFU_DCR_QUEUE_STATS_EN
    logic [31:0] stat_pushed_q, stat_dropped_q;
    logic        drop_any;

    // Writes ignored while flushing count as dropped too.
    assign drop_any = drop | ((state_q == DQ_FLUSH) & dcr.in_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pushed_q  <= '0;
            stat_dropped_q <= '0;
        end else if (flush) begin
            stat_pushed_q  <= '0;
            stat_dropped_q <= '0;
        end else begin
            if (push && stat_pushed_q != '1) begin
                stat_pushed_q <= stat_pushed_q + 32'd1;
            end
            if (drop_any && stat_dropped_q != '1) begin
                stat_dropped_q <= stat_dropped_q + 32'd1;
            end
        end
    end

    assign stat_pushed  = stat_pushed_q;
    assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_vx_afu_dcr_queue.sv
// Self-checking bench for vx_afu_dcr_queue: directed scenarios then random traffic against a queue model.
module tb_vx_afu_dcr_queue;
    import VX_gpu_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush, ap_start_in, ap_start_out, overflow, overflow_clr;
    logic [3:0] count;
`ifdef VX_AFU_DCR_QUEUE_STATS_EN
    logic [31:0] stat_pushed, stat_dropped;
`endif

    vx_afu_dcr_queue_if dcr ();

    vx_afu_dcr_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dcr          (dcr),
        .flush        (flush),
        .ap_start_in  (ap_start_in),
        .ap_start_out (ap_start_out),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .count        (count)
`ifdef VX_AFU_DCR_QUEUE_STATS_EN
        ,
        .stat_pushed  (stat_pushed),
        .stat_dropped (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: list of pending requests plus a "holding head after flush" flag.
    dcr_req_t    mq[$];
    logic        m_ovf      = 1'b0;
    logic        m_flushing = 1'b0;
    logic [31:0] m_pushed   = '0;
    logic [31:0] m_dropped  = '0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [11:0] ia, input logic [31:0] id,
                        input logic fl, input logic ordy, input logic aps, input logic oclr);
        int       sz;
        logic     pop, full, drop;
        dcr_req_t r, h;
        dcr.in_valid  = iv;
        dcr.in_addr   = ia;
        dcr.in_data   = id;
        flush         = fl;
        dcr.out_ready = ordy;
        ap_start_in   = aps;
        overflow_clr  = oclr;
        #4;
        sz = mq.size();
        check("out_valid", dcr.out_valid, sz != 0);
        if (sz != 0) begin
            check("out_addr", dcr.out_addr, mq[0].addr);
            check("out_data", dcr.out_data, mq[0].data);
        end
        check("count", count, sz);
        check("overflow", overflow, m_ovf);
        check("ap_start_out", ap_start_out, aps & (sz == 0) & ~iv & ~m_flushing);
`ifdef VX_AFU_DCR_QUEUE_STATS_EN
        check("stat_pushed", stat_pushed, m_pushed);
        check("stat_dropped", stat_dropped, m_dropped);
`endif
        @(posedge clk);
        pop  = (sz != 0) && ordy;
        full = (sz == DEPTH);
        drop = 1'b0;
        r.addr = ia;
        r.data = id;
        if (!m_flushing) begin
            if (fl) begin
                if (sz != 0 && !ordy) begin
                    h = mq[0];
                    mq.delete();
                    mq.push_back(h);
                    m_flushing = 1'b1;
                end else begin
                    mq.delete();
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (iv) begin
                    if (!full || pop) begin
                        mq.push_back(r);
                        if (m_pushed != '1) m_pushed++;
                    end else begin
                        drop = 1'b1;
                        if (m_dropped != '1) m_dropped++;
                    end
                end
            end
        end else begin
            if (iv && !fl && m_dropped != '1) m_dropped++;
            if (pop) begin
                void'(mq.pop_front());
                m_flushing = 1'b0;
            end
        end
        if (fl) begin
            m_pushed  = '0;
            m_dropped = '0;
        end
        if (drop) m_ovf = 1'b1;
        else if (oclr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic idle(input logic ordy, input logic aps);
        step(1'b0, 12'h0, 32'h0, 1'b0, ordy, aps, 1'b0);
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d, input logic ordy,
                        input logic aps);
        step(1'b1, a, d, 1'b0, ordy, aps, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        dcr.in_valid  = 1'b0;
        dcr.in_addr   = '0;
        dcr.in_data   = '0;
        dcr.out_ready = 1'b0;
        flush         = 1'b0;
        ap_start_in   = 1'b0;
        overflow_clr  = 1'b0;
        #12;
        check("rst_out_valid", dcr.out_valid, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ap_start", ap_start_out, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, immediate acceptance
        push(12'h001, 32'h11, 1'b1, 1'b0);
        check("t1_valid_next", dcr.out_valid, 1);
        check("t1_head_addr", dcr.out_addr, 12'h001);
        idle(1'b1, 1'b0);
        check("t1_count", count, 0);
        check("t1_overflow", overflow, 0);

        // Overfill, clear overflow, drain in order
        for (int i = 1; i <= 9; i++) push(12'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        check("t2_count_full", count, 8);
        check("t2_overflow_set", overflow, 1);
        step(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_overflow_clr", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            check("t2_order", dcr.out_data, 32'h100 + 32'(i));
            idle(1'b1, 1'b0);
        end
        check("t2_drained", count, 0);

        // Push and pop while full
        for (int i = 0; i < 8; i++) push(12'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
        push(12'h3AA, 32'h2FF, 1'b1, 1'b0);
        check("t3_count", count, 8);
        check("t3_overflow", overflow, 0);
        for (int i = 1; i < 8; i++) begin
            check("t3_order", dcr.out_data, 32'h200 + 32'(i));
            idle(1'b1, 1'b0);
        end
        check("t3_last", dcr.out_data, 32'h2FF);
        idle(1'b1, 1'b0);

        // Start gating
        for (int i = 0; i < 3; i++) push(12'h40 + 12'(i), 32'h400 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
        check("t4_start", ap_start_out, 1);
        idle(1'b0, 1'b1);
        push(12'h44, 32'h444, 1'b0, 1'b1);
        idle(1'b1, 1'b1);

        // Flush with a stalled head
        for (int i = 0; i < 4; i++) push(12'h50 + 12'(i), 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_count_hold", count, 1);
        for (int i = 0; i < 3; i++) push(12'h5F, 32'h5EE, 1'b0, 1'b1);
        check("t5_head_stable", dcr.out_data, 32'h500);
        check("t5_count_still", count, 1);
        check("t5_no_overflow", overflow, 0);
        idle(1'b1, 1'b0);
        check("t5_empty", count, 0);
        push(12'h5A, 32'h5AA, 1'b0, 1'b0);
        check("t5_run_again", count, 1);
        idle(1'b1, 1'b0);

`ifdef VX_AFU_DCR_QUEUE_STATS_EN
        step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) push(12'h60 + 12'(i), 32'h600 + 32'(i), 1'b0, 1'b0);
        check("t6_pushed", stat_pushed, 8);
        check("t6_dropped", stat_dropped, 2);
        step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6_pushed_clr", stat_pushed, 0);
        check("t6_dropped_clr", stat_dropped, 0);
        idle(1'b1, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom), $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1, 1'b1);
        check("final_empty", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
